// File: rtl/des_pkg.sv
// des_pkg: shared constants, state encoding and table-driven helpers for the
// iterative DES datapath.
//   - Width constants for the block, half-block, round key and C/D halves.
//   - IP, FP, E and P permutation tables (1-based DES bit positions, where
//     DES bit 1 is the MSB of the vector).
//   - The eight S-boxes, one 64-bit word per row holding sixteen 4-bit
//     entries with column 0 in the top nibble.
//   - Permutation / lookup functions used by the top level and by des_f.
package des_pkg;

    localparam int BLOCK_W = 64;
    localparam int KEY_W   = 48;
    localparam int HALF_W  = 32;
    localparam int CD_W    = 28;

    localparam logic [3:0] LAST_RND = 4'd15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [7:0] IP_TAB [64] = '{
        8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18, 8'd10, 8'd2,
        8'd60, 8'd52, 8'd44, 8'd36, 8'd28, 8'd20, 8'd12, 8'd4,
        8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22, 8'd14, 8'd6,
        8'd64, 8'd56, 8'd48, 8'd40, 8'd32, 8'd24, 8'd16, 8'd8,
        8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,  8'd1,
        8'd59, 8'd51, 8'd43, 8'd35, 8'd27, 8'd19, 8'd11, 8'd3,
        8'd61, 8'd53, 8'd45, 8'd37, 8'd29, 8'd21, 8'd13, 8'd5,
        8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15, 8'd7
    };

    localparam logic [7:0] FP_TAB [64] = '{
        8'd40, 8'd8, 8'd48, 8'd16, 8'd56, 8'd24, 8'd64, 8'd32,
        8'd39, 8'd7, 8'd47, 8'd15, 8'd55, 8'd23, 8'd63, 8'd31,
        8'd38, 8'd6, 8'd46, 8'd14, 8'd54, 8'd22, 8'd62, 8'd30,
        8'd37, 8'd5, 8'd45, 8'd13, 8'd53, 8'd21, 8'd61, 8'd29,
        8'd36, 8'd4, 8'd44, 8'd12, 8'd52, 8'd20, 8'd60, 8'd28,
        8'd35, 8'd3, 8'd43, 8'd11, 8'd51, 8'd19, 8'd59, 8'd27,
        8'd34, 8'd2, 8'd42, 8'd10, 8'd50, 8'd18, 8'd58, 8'd26,
        8'd33, 8'd1, 8'd41, 8'd9,  8'd49, 8'd17, 8'd57, 8'd25
    };

    localparam logic [7:0] E_TAB [48] = '{
        8'd32, 8'd1,  8'd2,  8'd3,  8'd4,  8'd5,
        8'd4,  8'd5,  8'd6,  8'd7,  8'd8,  8'd9,
        8'd8,  8'd9,  8'd10, 8'd11, 8'd12, 8'd13,
        8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17,
        8'd16, 8'd17, 8'd18, 8'd19, 8'd20, 8'd21,
        8'd20, 8'd21, 8'd22, 8'd23, 8'd24, 8'd25,
        8'd24, 8'd25, 8'd26, 8'd27, 8'd28, 8'd29,
        8'd28, 8'd29, 8'd30, 8'd31, 8'd32, 8'd1
    };

    localparam logic [7:0] P_TAB [32] = '{
        8'd16, 8'd7,  8'd20, 8'd21, 8'd29, 8'd12, 8'd28, 8'd17,
        8'd1,  8'd15, 8'd23, 8'd26, 8'd5,  8'd18, 8'd31, 8'd10,
        8'd2,  8'd8,  8'd24, 8'd14, 8'd32, 8'd27, 8'd3,  8'd9,
        8'd19, 8'd13, 8'd30, 8'd6,  8'd22, 8'd11, 8'd4,  8'd25
    };

    // [box][row]; each row packs columns 0..15 from the top nibble down
    localparam logic [63:0] SBOX_TAB [8][4] = '{
        '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
        '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
        '{64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
        '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
        '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
        '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
        '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
        '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
    };

    // Initial permutation; DES bit n lives at vector index 64-n
    function automatic logic [BLOCK_W-1:0] ip_perm(input logic [BLOCK_W-1:0] d);
        logic [BLOCK_W-1:0] r;
        r = '0;
        for (int i = 0; i < BLOCK_W; i++) begin
            r[6'(BLOCK_W - 1 - i)] = d[6'(BLOCK_W - int'(IP_TAB[6'(i)]))];
        end
        return r;
    endfunction

    // Final permutation (inverse of IP)
    function automatic logic [BLOCK_W-1:0] fp_perm(input logic [BLOCK_W-1:0] d);
        logic [BLOCK_W-1:0] r;
        r = '0;
        for (int i = 0; i < BLOCK_W; i++) begin
            r[6'(BLOCK_W - 1 - i)] = d[6'(BLOCK_W - int'(FP_TAB[6'(i)]))];
        end
        return r;
    endfunction

    // 32 -> 48 expansion
    function automatic logic [KEY_W-1:0] e_expand(input logic [HALF_W-1:0] d);
        logic [KEY_W-1:0] r;
        r = '0;
        for (int i = 0; i < KEY_W; i++) begin
            r[6'(KEY_W - 1 - i)] = d[5'(HALF_W - int'(E_TAB[6'(i)]))];
        end
        return r;
    endfunction

    // 32-bit straight permutation applied after the S-boxes
    function automatic logic [HALF_W-1:0] p_perm(input logic [HALF_W-1:0] d);
        logic [HALF_W-1:0] r;
        r = '0;
        for (int i = 0; i < HALF_W; i++) begin
            r[5'(HALF_W - 1 - i)] = d[5'(HALF_W - int'(P_TAB[5'(i)]))];
        end
        return r;
    endfunction

    // Row = outer bits {b5,b0}, column = inner bits b4..b1
    function automatic logic [3:0] sbox(input logic [2:0] box, input logic [5:0] b);
        logic [63:0] row;
        logic [3:0]  col;
        row = SBOX_TAB[box][{b[5], b[0]}];
        col = b[4:1];
        return 4'(row >> {4'd15 - col, 2'b00});
    endfunction

endpackage

// File: rtl/des_round_engine_f.sv
// des_f: combinational DES f-function.
//   r : 32-bit right half entering the round
//   k : 48-bit round key
//   f : 32-bit result P(S(E(r) ^ k))
module des_f
    import des_pkg::*;
(
    input  logic [HALF_W-1:0] r,
    input  logic [KEY_W-1:0]  k,
    output logic [HALF_W-1:0] f
);

    logic [KEY_W-1:0]  x_s;
    logic [HALF_W-1:0] s_out_s;

    // Expand the half block and mix in the round key
    always_comb begin
        x_s = e_expand(r) ^ k;
    end

    // Eight 6->4 substitutions; box 1 takes the most significant six bits
    for (genvar g = 0; g < 8; g++) begin : g_sbox
        assign s_out_s[HALF_W - 1 - 4*g -: 4] = sbox(3'(g), x_s[KEY_W - 1 - 6*g -: 6]);
    end

    // Final straight permutation
    always_comb begin
        f = p_perm(s_out_s);
    end

endmodule

// File: rtl/des_round_engine.sv
// des_round_engine: iterative DES encrypt/decrypt, one Feistel round per clock.
//   clk, rst_n              clock and asynchronous active-low reset
//   in_valid / in_ready     input handshake; in_ready only while idle
//   data_in, decrypt        block and direction, captured at accept
//   r_key1 .. r_key16       round keys from the upstream key schedule, held
//                           stable for the whole operation
//   out_valid / out_ready   output handshake; result held until taken
//   data_out                registered result
//   busy                    high while rounding or holding a result
module des_round_engine
    import des_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] data_in,
    input  logic               decrypt,
    input  logic [KEY_W-1:0]   r_key1,
    input  logic [KEY_W-1:0]   r_key2,
    input  logic [KEY_W-1:0]   r_key3,
    input  logic [KEY_W-1:0]   r_key4,
    input  logic [KEY_W-1:0]   r_key5,
    input  logic [KEY_W-1:0]   r_key6,
    input  logic [KEY_W-1:0]   r_key7,
    input  logic [KEY_W-1:0]   r_key8,
    input  logic [KEY_W-1:0]   r_key9,
    input  logic [KEY_W-1:0]   r_key10,
    input  logic [KEY_W-1:0]   r_key11,
    input  logic [KEY_W-1:0]   r_key12,
    input  logic [KEY_W-1:0]   r_key13,
    input  logic [KEY_W-1:0]   r_key14,
    input  logic [KEY_W-1:0]   r_key15,
    input  logic [KEY_W-1:0]   r_key16,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] data_out,
    output logic               busy
);

    state_e             state_r;
    state_e             next_state_s;
    logic [HALF_W-1:0]  l_r;
    logic [HALF_W-1:0]  r_r;
    logic [3:0]         rnd_r;
    logic               dec_q_r;
    logic [BLOCK_W-1:0] data_out_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               busy_r;

    logic               accept_s;
    logic               last_s;
    logic [3:0]         key_idx_s;
    logic [KEY_W-1:0]   key_s;
    logic [HALF_W-1:0]  f_s;
    logic [HALF_W-1:0]  r_new_s;
    logic [BLOCK_W-1:0] ip_s;

    // Handshake qualifiers; in_ready_r also keeps the first post-reset cycle closed
    always_comb begin
        accept_s = 1'b0;
        last_s   = 1'b0;
        if (state_r == IDLE) begin
            accept_s = in_valid & in_ready_r;
        end else begin
            accept_s = 1'b0;
        end
        if ((state_r == ROUND) && (rnd_r == LAST_RND)) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
    end

    // Next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = ROUND;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ROUND: begin
                if (last_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = ROUND;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Decryption walks the key list backwards
    always_comb begin
        key_idx_s = 4'd0;
        if (dec_q_r) begin
            key_idx_s = LAST_RND - rnd_r;
        end else begin
            key_idx_s = rnd_r;
        end
    end

    // 16:1 round-key mux
    always_comb begin
        key_s = '0;
        case (key_idx_s)
            4'd0:    key_s = r_key1;
            4'd1:    key_s = r_key2;
            4'd2:    key_s = r_key3;
            4'd3:    key_s = r_key4;
            4'd4:    key_s = r_key5;
            4'd5:    key_s = r_key6;
            4'd6:    key_s = r_key7;
            4'd7:    key_s = r_key8;
            4'd8:    key_s = r_key9;
            4'd9:    key_s = r_key10;
            4'd10:   key_s = r_key11;
            4'd11:   key_s = r_key12;
            4'd12:   key_s = r_key13;
            4'd13:   key_s = r_key14;
            4'd14:   key_s = r_key15;
            4'd15:   key_s = r_key16;
            default: key_s = '0;
        endcase
    end

    des_f u_f (
        .r (r_r),
        .k (key_s),
        .f (f_s)
    );

    // Round combine and input permutation
    always_comb begin
        r_new_s = l_r ^ f_s;
        ip_s    = ip_perm(data_in);
    end

    // State register and flags registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            in_ready_r  <= (next_state_s == IDLE);
            out_valid_r <= (next_state_s == DONE);
            busy_r      <= (next_state_s != IDLE);
        end
    end

    // Feistel datapath, round counter and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_r        <= '0;
            r_r        <= '0;
            rnd_r      <= 4'd0;
            dec_q_r    <= 1'b0;
            data_out_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        l_r     <= ip_s[BLOCK_W-1:HALF_W];
                        r_r     <= ip_s[HALF_W-1:0];
                        dec_q_r <= decrypt;
                        rnd_r   <= 4'd0;
                    end
                end
                ROUND: begin
                    l_r   <= r_r;
                    r_r   <= r_new_s;
                    rnd_r <= rnd_r + 4'd1;
                    // Final output skips the last swap: FP(R16, L16)
                    if (last_s) begin
                        data_out_r <= fp_perm({r_new_s, r_r});
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign data_out  = data_out_r;

endmodule

// File: tb/tb_des_round_engine.sv
// tb_des_round_engine: directed-vector bench with a result scoreboard.
// Round keys come from a small key-schedule model here; expected results are
// the published DES vectors.
module tb_des_round_engine;
    import des_pkg::*;

    localparam logic [63:0] KEY_A = 64'h133457799BBCDFF1;
    localparam logic [63:0] PT_A  = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT_A  = 64'h85E813540F0AB405;
    localparam logic [63:0] CT_Z  = 64'h8CA64DE9C1B123A7;

    localparam int PC1 [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18,
                                10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
                                63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                                14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int PC2 [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10,
                                23,19,12,4,26,8, 16,7,27,20,13,2,
                                41,52,31,37,47,55, 30,40,51,45,33,48,
                                44,49,39,56,34,53, 46,42,50,36,29,32};
    localparam int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        decrypt = 1'b0;
    logic        out_ready = 1'b0;
    logic [63:0] data_in = 64'd0;
    logic [47:0] rk [16];
    logic        in_ready;
    logic        out_valid;
    logic        busy;
    logic [63:0] data_out;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q [$];
    logic [63:0] mon_exp;

    always #5 clk = ~clk;

    des_round_engine dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .data_in(data_in), .decrypt(decrypt),
        .r_key1(rk[0]),   .r_key2(rk[1]),   .r_key3(rk[2]),   .r_key4(rk[3]),
        .r_key5(rk[4]),   .r_key6(rk[5]),   .r_key7(rk[6]),   .r_key8(rk[7]),
        .r_key9(rk[8]),   .r_key10(rk[9]),  .r_key11(rk[10]), .r_key12(rk[11]),
        .r_key13(rk[12]), .r_key14(rk[13]), .r_key15(rk[14]), .r_key16(rk[15]),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .busy(busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Standard DES key schedule: PC1, per-round left rotations, PC2
    task automatic set_key(input logic [63:0] key);
        logic [55:0]     cd;
        logic [CD_W-1:0] c;
        logic [CD_W-1:0] d;
        for (int i = 0; i < 56; i++) cd[6'(55 - i)] = key[6'(64 - PC1[i])];
        c = cd[55:28];
        d = cd[27:0];
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < SHIFTS[r]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) rk[4'(r)][6'(47 - i)] = cd[6'(56 - PC2[i])];
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for idle, offers one block, then counts cycles until out_valid
    task automatic start_block(input logic [63:0] din, input logic dec,
                               input logic [63:0] exp, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 40) begin
            step();
            w++;
        end
        check("in_ready_wait", {63'd0, in_ready}, 64'd1);
        data_in  = din;
        decrypt  = dec;
        in_valid = 1'b1;
        exp_q.push_back(exp);
        step();
        in_valid = 1'b0;
        data_in  = 64'hA5A5_A5A5_A5A5_A5A5;
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
    endtask

    // Scoreboard monitor: every accepted result is matched against the queue
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL result_unexpected: got %h expected no output", data_out);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("result", data_out, mon_exp);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int lat;
        int n_acc;
        int cyc;
        int acc_cyc [2];

        // Reset values
        set_key(KEY_A);
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_data_out", data_out, 64'd0);
        rst_n = 1'b1;
        step();
        check("in_ready_after_reset", {63'd0, in_ready}, 64'd1);

        // Standard encrypt vector with latency
        out_ready = 1'b1;
        start_block(PT_A, 1'b0, CT_A, lat);
        check("latency_encrypt", 64'(lat), 64'd16);
        check("busy_in_done", {63'd0, busy}, 64'd1);
        step();
        check("idle_after_done", {63'd0, in_ready}, 64'd1);

        // Decrypt round trip
        start_block(CT_A, 1'b1, PT_A, lat);
        check("latency_decrypt", 64'(lat), 64'd16);
        step();

        // All-zero key and data
        set_key(64'd0);
        start_block(64'd0, 1'b0, CT_Z, lat);
        step();

        // Backpressure: result held, in_valid ignored
        set_key(KEY_A);
        out_ready = 1'b0;
        start_block(PT_A, 1'b0, CT_A, lat);
        for (int j = 0; j < 5; j++) begin
            in_valid = (j % 2 == 0);
            data_in  = 64'hFFFF_FFFF_FFFF_FFFF;
            step();
            check("bp_out_valid", {63'd0, out_valid}, 64'd1);
            check("bp_data_out", data_out, CT_A);
            check("bp_in_ready", {63'd0, in_ready}, 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_release_idle", {63'd0, in_ready}, 64'd1);
        check("bp_release_out_valid", {63'd0, out_valid}, 64'd0);

        // Back-to-back blocks with in_valid and out_ready held high
        n_acc = 0;
        cyc = 0;
        acc_cyc[0] = 0;
        acc_cyc[1] = 0;
        while (cyc < 80 && (n_acc < 2 || exp_q.size() > 0)) begin
            data_in  = (n_acc == 0) ? PT_A : CT_A;
            decrypt  = (n_acc == 0) ? 1'b0 : 1'b1;
            in_valid = (n_acc < 2);
            if (in_valid && in_ready) begin
                acc_cyc[n_acc] = cyc;
                exp_q.push_back((n_acc == 0) ? CT_A : PT_A);
                n_acc++;
            end
            step();
            cyc++;
        end
        in_valid = 1'b0;
        check("b2b_accepts", 64'(n_acc), 64'd2);
        check("b2b_spacing", 64'(acc_cyc[1] - acc_cyc[0]), 64'd18);

        // Reset in the middle of a block
        data_in  = PT_A;
        decrypt  = 1'b0;
        in_valid = 1'b1;
        exp_q.push_back(CT_A);
        step();
        in_valid = 1'b0;
        repeat (8) step();
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("abort_out_valid", {63'd0, out_valid}, 64'd0);
        check("abort_data_out", data_out, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("abort_in_ready", {63'd0, in_ready}, 64'd1);
        start_block(PT_A, 1'b0, CT_A, lat);
        check("latency_after_abort", 64'(lat), 64'd16);
        step();
        step();

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
